// File: rtl/uart_adder_ctrl.sv
// Sequencer between the UART RX/TX and a 16-bit adder: gathers two little-endian
// operands, registers the 17-bit sum and returns it as three bytes.
module uart_adder_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic [15:0] add_a_o,
  output logic [15:0] add_b_o,
  output logic        add_cin_o,
  input  logic [15:0] add_s_i,
  input  logic        add_cout_i,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        overrun_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [3:0] {
    RX_A0, RX_A1, RX_B0, RX_B1, CALC,
    TX_S0, WT_S0, TX_S1, WT_S1, TX_C, WT_C
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          cout_q, cout_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          timeout_q, timeout_d;
  logic          overrun_q, overrun_d;
  logic          wt_leave;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= RX_A0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  // tx_start_q is high exactly in the first WT cycle, which doubles as the busy guard
  assign wt_leave = !tx_start_q && !tx_busy_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;

    case (state_q)
      RX_A0: begin
        cnt_d = '0;
        if (rx_valid_i) begin
          a_d[7:0] = rx_data_i;
          state_d  = RX_A1;
        end
      end
      RX_A1, RX_B0, RX_B1: begin
        if (rx_valid_i) begin
          cnt_d = '0;
          case (state_q)
            RX_A1:   begin a_d[15:8] = rx_data_i; state_d = RX_B0; end
            RX_B0:   begin b_d[7:0]  = rx_data_i; state_d = RX_B1; end
            default: begin b_d[15:8] = rx_data_i; state_d = CALC;  end
          endcase
        end else if (TO_EN && cnt_q == TC_LAST) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = RX_A0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CALC: begin
        sum_d   = add_s_i;
        cout_d  = add_cout_i;
        state_d = TX_S0;
      end
      TX_S0: if (!tx_busy_i) begin
        tx_data_d  = sum_q[7:0];
        tx_start_d = 1'b1;
        state_d    = WT_S0;
      end
      TX_S1: if (!tx_busy_i) begin
        tx_data_d  = sum_q[15:8];
        tx_start_d = 1'b1;
        state_d    = WT_S1;
      end
      TX_C: if (!tx_busy_i) begin
        tx_data_d  = {7'b0, cout_q};
        tx_start_d = 1'b1;
        state_d    = WT_C;
      end
      WT_S0:   if (wt_leave) state_d = TX_S1;
      WT_S1:   if (wt_leave) state_d = TX_C;
      WT_C:    if (wt_leave) state_d = RX_A0;
      default: state_d = RX_A0;
    endcase

    if (rx_valid_i && !(state_q inside {RX_A0, RX_A1, RX_B0, RX_B1})) overrun_d = 1'b1;
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign add_a_o    = a_q;
  assign add_b_o    = b_q;
  assign add_cin_o  = 1'b0;
  assign busy_o     = (state_q != RX_A0);
  assign timeout_o  = timeout_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_adder_ctrl.sv
// Scoreboard bench for uart_adder_ctrl: directed frames queue their expected TX
// bytes, an independent monitor pops and compares on every tx_start_o.
module tb_uart_adder_ctrl;

  logic        clk;
  logic        rst_ni;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        busy, timeout, overrun;

  logic        busy_model, busy_force;
  int          n_checks, n_fail;
  int          tmo_cnt, ovr_cnt;
  logic [7:0]  exp_q[$];

  assign tx_busy = busy_model | busy_force;
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  uart_adder_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_busy_i(tx_busy),
    .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
    .add_s_i(add_s), .add_cout_i(add_cout),
    .busy_o(busy), .timeout_o(timeout), .overrun_o(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // TX model: busy rises the cycle after tx_start and stays up for 4 cycles
  initial begin
    busy_model = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk); #1 busy_model = 1'b1;
        repeat (4) @(posedge clk);
        #1 busy_model = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (timeout) tmo_cnt++;
    if (overrun) ovr_cnt++;
    if (tx_start) begin
      chk("tx_start_while_busy", {31'b0, tx_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx_start: got data %0h, expected no transmission", tx_data);
      end else begin
        chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, b3, input logic [7:0] e0, e1, e2);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    send(b0); send(b1); send(b2); send(b3);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    chk(name, {31'b0, done}, 32'd1);
  endtask

  task automatic wait_start(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {tx_data, tx_start, add_cin, busy, timeout, overrun}, 32'd0);
    chk({name, "_ops"}, {add_a, add_b}, 32'd0);
  endtask

  int   t0, o0, starts;
  logic seen;

  initial begin
    n_checks = 0; n_fail = 0; tmo_cnt = 0; ovr_cnt = 0;
    rst_ni = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; busy_force = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_ni = 1'b1;

    // basic frame
    exp_q.push_back(8'hAC); exp_q.push_back(8'h68); exp_q.push_back(8'h00);
    send(8'h34);
    chk("busy_after_first_byte", {31'b0, busy}, 32'd1);
    send(8'h12);
    chk("add_a_after_two", {16'b0, add_a}, 32'h1234);
    send(8'h78); send(8'h56);
    chk("add_b", {16'b0, add_b}, 32'h5678);
    wait_idle("frame1_done");

    frame(8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01);
    wait_idle("frame_carry_done");

    // partial frame dropped after 16 idle cycles, operands kept
    t0 = tmo_cnt;
    send(8'h11); send(8'h22);
    repeat (20) @(negedge clk);
    chk("timeout_pulses", tmo_cnt - t0, 32'd1);
    chk("state_idle_after_timeout", {31'b0, busy}, 32'd0);
    chk("a_kept_after_timeout", {16'b0, add_a}, 32'h2211);
    frame(8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00);
    wait_idle("frame_after_timeout_done");

    // byte arriving on the terminal-count cycle wins over the timeout
    t0 = tmo_cnt;
    exp_q.push_back(8'h0C); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send(8'h05); send(8'h00);
    repeat (14) @(posedge clk);
    send(8'h07); send(8'h00);
    wait_idle("boundary_frame_done");
    chk("no_timeout_at_boundary", tmo_cnt - t0, 32'd0);

    // TX held busy for 50 cycles
    busy_force = 1'b1;
    frame(8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h00);
    starts = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    chk("no_start_while_busy", starts, 32'd0);
    @(posedge clk); #1 busy_force = 1'b0;
    @(negedge clk);
    chk("start_not_before_release", {31'b0, tx_start}, 32'd0);
    @(negedge clk);
    chk("start_cycle_after_release", {31'b0, tx_start}, 32'd1);
    wait_idle("busy_hold_done");

    // overrun injected during WT_S1
    chk("no_overrun_so_far", ovr_cnt, 32'd0);
    o0 = ovr_cnt;
    frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h06, 8'h00);
    wait_start(seen);
    if (seen) wait_start(seen);
    chk("reached_wt_s1", {31'b0, seen}, 32'd1);
    rx_data = 8'hEE; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    wait_idle("overrun_frame_done");
    chk("overrun_pulses", ovr_cnt - o0, 32'd1);
    chk("ops_after_overrun", {add_a, add_b}, 32'h0201_0403);

    // reset during WT_S0: only the first byte ever goes out
    exp_q.push_back(8'hFF);
    send(8'hAA); send(8'h00); send(8'h55); send(8'h00);
    wait_start(seen);
    chk("reached_wt_s0", {31'b0, seen}, 32'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset_mid_tx");
    rst_ni = 1'b1;
    starts = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    chk("no_start_after_reset", starts, 32'd0);
    frame(8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00);
    wait_idle("frame_after_reset_done");

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
